// File: rtl/shift_ex_stage_pkg.sv
// Shared definitions for the shift execute stage: MIPS shift funct codes
// and the storage entry layout used by the output and skid registers.
package shift_ex_stage_pkg;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    // Tag width held in an entry; the top-level TAG_W must match it.
    localparam int ENTRY_TAG_W = 5;

    typedef struct packed {
        logic [31:0]            result;
        logic [ENTRY_TAG_W-1:0] tag;
        logic                   err;
        logic                   valid;
    } entry_t;

endpackage

// File: rtl/shift_ex_stage_if.sv
// ID-side and MEM/WB-side handshake bundle of the shift execute stage.
// master: the surrounding pipeline (drives operands, consumes results).
// slave:  the execute stage itself.
interface shift_ex_stage_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_funct;
    logic [4:0]       in_shamt;
    logic [31:0]      in_rs;
    logic [31:0]      in_rt;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_funct, in_shamt, in_rs, in_rt, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_funct, in_shamt, in_rs, in_rt, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_err
    );

endinterface

// File: rtl/shift_ex_stage_barrel_shift32.sv
// Combinational 32-bit barrel shifter: five log-stages of 1/2/4/8/16 bits.
// Right shifts fill with rt[31] when arith is set, otherwise with zero.
module barrel_shift32 (
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    input  logic        right,
    input  logic        arith,
    output logic [31:0] result
);

    logic             fill;
    logic [5:0][31:0] stage;

    assign fill     = arith & data[31];
    assign stage[0] = data;

    for (genvar i = 0; i < 5; i++) begin : g_stage
        localparam int SH = 1 << i;
        logic [31:0] shl;
        logic [31:0] shr;
        assign shl          = {stage[i][31-SH:0], {SH{1'b0}}};
        assign shr          = {{SH{fill}}, stage[i][31:SH]};
        assign stage[i+1]   = !amt[i] ? stage[i] : (right ? shr : shl);
    end

    assign result = stage[5];

endmodule

// File: rtl/shift_ex_stage.sv
// Execute-stage front end for MIPS shifts. Decodes funct, shifts rt, and
// registers the result into a 2-entry (OUT + SKID) buffer so that in_ready
// depends only on stored state, never on out_ready.
module shift_ex_stage
    import shift_ex_stage_pkg::*;
#(
    parameter int TAG_W = ENTRY_TAG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    shift_ex_stage_if.slave  bus,
    output logic [CNT_W-1:0] op_count
);

    logic [4:0]       amt;
    logic             right;
    logic             arith;
    logic             illegal;
    logic [31:0]      shifted;
    logic [TAG_W-1:0] tag_in;
    logic             unused_rs_hi;
    entry_t           new_e;
    entry_t           out_q;
    entry_t           skid_q;
    logic             accept;
    logic             deliver;

    // Only rs[4:0] carries an amount; the upper bits are don't-care.
    assign unused_rs_hi = ^bus.in_rs[31:5];
    assign tag_in       = bus.in_tag;

    // Funct decode into shifter controls; unknown functs flag an error.
    always_comb begin
        amt     = bus.in_shamt;
        right   = 1'b0;
        arith   = 1'b0;
        illegal = 1'b0;
        case (bus.in_funct)
            FN_SLL:  ;
            FN_SRL:  right = 1'b1;
            FN_SRA:  begin right = 1'b1; arith = 1'b1; end
            FN_SLLV: amt = bus.in_rs[4:0];
            FN_SRLV: begin amt = bus.in_rs[4:0]; right = 1'b1; end
            FN_SRAV: begin amt = bus.in_rs[4:0]; right = 1'b1; arith = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

    barrel_shift32 u_shift (
        .data   (bus.in_rt),
        .amt    (amt),
        .right  (right),
        .arith  (arith),
        .result (shifted)
    );

    // Entry presented for storage when an op is accepted.
    always_comb begin
        new_e        = '0;
        new_e.result = illegal ? 32'h0 : shifted;
        new_e.tag    = tag_in;
        new_e.err    = illegal;
        new_e.valid  = 1'b1;
    end

    assign bus.in_ready   = !skid_q.valid;
    assign bus.out_valid  = out_q.valid;
    assign bus.out_result = out_q.result;
    assign bus.out_tag    = out_q.tag;
    assign bus.out_err    = out_q.err;

    assign accept  = bus.in_valid & bus.in_ready;
    assign deliver = out_q.valid & bus.out_ready;

    // OUT/SKID occupancy update and delivered-op counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            skid_q   <= '0;
            op_count <= '0;
        end else begin
            if (deliver) begin
                op_count <= op_count + 1'b1;
            end
            case ({accept, deliver})
                2'b01: begin
                    if (skid_q.valid) begin
                        out_q <= skid_q;
                    end else begin
                        out_q <= '0;
                    end
                    skid_q <= '0;
                end
                2'b10: begin
                    if (!out_q.valid) begin
                        out_q <= new_e;
                    end else begin
                        skid_q <= new_e;
                    end
                end
                // Accept implies SKID is empty, so OUT simply refills.
                2'b11: out_q <= new_e;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_ex_stage.sv
// Self-checking bench for shift_ex_stage: directed cases followed by a
// randomized valid/ready stream checked against a queue-based model.
module tb_shift_ex_stage;
    import shift_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] op_count;
    int          n_checks = 0;
    int          n_fail   = 0;

    shift_ex_stage_if #(.TAG_W(5)) bus ();

    shift_ex_stage #(.TAG_W(5), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {err, result} straight from the shift definitions.
    function automatic logic [32:0] model(input logic [5:0] f, input logic [4:0] sh,
                                          input logic [31:0] rs, input logic [31:0] rt);
        case (f)
            FN_SLL:  return {1'b0, rt << sh};
            FN_SRL:  return {1'b0, rt >> sh};
            FN_SRA:  return {1'b0, 32'($signed(rt) >>> sh)};
            FN_SLLV: return {1'b0, rt << rs[4:0]};
            FN_SRLV: return {1'b0, rt >> rs[4:0]};
            FN_SRAV: return {1'b0, 32'($signed(rt) >>> rs[4:0])};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic drive(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] tag);
        bus.in_funct = f;
        bus.in_shamt = sh;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
    endtask

    // One accepted op with out_ready=1, checked on the following cycle.
    task automatic do_op(input string name, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] tag,
                         input logic [31:0] exp_res, input logic exp_err);
        drive(f, sh, rs, rt, tag);
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_result"}, bus.out_result, exp_res);
        check({name, "_err"}, 32'(bus.out_err), 32'(exp_err));
        check({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    endtask

    logic [31:0] q_res[$];
    logic [4:0]  q_tag[$];
    logic        q_err[$];

    initial begin
        int          sent;
        int          got;
        int          cycles;
        logic        prev_ready;
        logic        accepted;
        logic [32:0] m;
        logic [5:0]  fsel;
        logic [5:0]  legal [6];

        legal = '{FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_funct  = '0;
        bus.in_shamt  = '0;
        bus.in_rs     = '0;
        bus.in_rt     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_result", bus.out_result, 32'd0);
        check("rst_tag", 32'(bus.out_tag), 32'd0);
        check("rst_err", 32'(bus.out_err), 32'd0);

        // sra of the sign bit
        bus.out_ready = 1'b1;
        do_op("sra4", FN_SRA, 5'd4, 32'h0, 32'h8000_0000, 5'd1, 32'hF800_0000, 1'b0);
        tick();
        check("sra4_count", 32'(op_count), 32'd1);
        check("sra4_drained", 32'(bus.out_valid), 32'd0);

        // Back-to-back variable and boundary shifts
        do_op("srlv3", FN_SRLV, 5'd0, 32'hFFFF_FF23, 32'h0000_00F0, 5'd2, 32'h0000_001E, 1'b0);
        do_op("sllv3", FN_SLLV, 5'd0, 32'hFFFF_FF23, 32'h0000_00F0, 5'd3, 32'h0000_0780, 1'b0);
        do_op("sll0", FN_SLL, 5'd0, 32'h0, 32'h1234_5678, 5'd4, 32'h1234_5678, 1'b0);
        do_op("sra31", FN_SRA, 5'd31, 32'h0, 32'h8000_0000, 5'd5, 32'hFFFF_FFFF, 1'b0);
        do_op("srl31", FN_SRL, 5'd31, 32'h0, 32'h8000_0000, 5'd6, 32'h0000_0001, 1'b0);
        do_op("srav0", FN_SRAV, 5'd7, 32'h0000_0020, 32'h8000_0000, 5'd7, 32'h8000_0000, 1'b0);
        tick();
        check("dir_count", 32'(op_count), 32'd7);

        // Backpressure: tags 1,2 accepted, 3 held by the source
        bus.out_ready = 1'b0;
        drive(FN_SLL, 5'd0, 32'h0, 32'h1111_1111, 5'd1);
        tick();
        check("bp_t1_valid", 32'(bus.out_valid), 32'd1);
        check("bp_t1_in_ready", 32'(bus.in_ready), 32'd1);
        drive(FN_SLL, 5'd0, 32'h0, 32'h2222_2222, 5'd2);
        tick();
        check("bp_t2_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_t2_out_tag", 32'(bus.out_tag), 32'd1);
        drive(FN_SLL, 5'd0, 32'h0, 32'h3333_3333, 5'd3);
        tick();
        check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_hold_tag", 32'(bus.out_tag), 32'd1);
        check("bp_hold_result", bus.out_result, 32'h1111_1111);
        bus.out_ready = 1'b1;
        tick();
        check("bp_d2_tag", 32'(bus.out_tag), 32'd2);
        check("bp_d2_result", bus.out_result, 32'h2222_2222);
        check("bp_d2_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_d3_tag", 32'(bus.out_tag), 32'd3);
        check("bp_d3_result", bus.out_result, 32'h3333_3333);
        tick();
        check("bp_empty", 32'(bus.out_valid), 32'd0);
        check("bp_count", 32'(op_count), 32'd10);

        // Illegal funct
        do_op("illegal", 6'h20, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd12, 32'h0, 1'b1);
        tick();
        check("illegal_count", 32'(op_count), 32'd11);

        // Reset with OUT and SKID both full
        bus.out_ready = 1'b0;
        drive(FN_SLL, 5'd1, 32'h0, 32'h0000_0009, 5'd9);
        tick();
        drive(FN_SLL, 5'd1, 32'h0, 32'h0000_000A, 5'd10);
        tick();
        check("rm_full_in_ready", 32'(bus.in_ready), 32'd0);
        check("rm_full_out_valid", 32'(bus.out_valid), 32'd1);
        drive(FN_SLL, 5'd1, 32'h0, 32'h0000_000B, 5'd11);
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rm_out_valid", 32'(bus.out_valid), 32'd0);
        check("rm_in_ready", 32'(bus.in_ready), 32'd1);
        check("rm_count", 32'(op_count), 32'd0);
        check("rm_result", bus.out_result, 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rm_no_stale", 32'(bus.out_valid), 32'd0);
        end
        check("rm_count_after", 32'(op_count), 32'd0);

        // Randomized streaming against the queue model
        sent       = 0;
        got        = 0;
        cycles     = 0;
        prev_ready = 1'b0;
        while ((sent < 1000 || q_res.size() != 0) && cycles < 20000) begin
            if (!bus.in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    fsel = 6'($urandom);
                end else begin
                    fsel = legal[$urandom_range(0, 5)];
                end
                drive(fsel, 5'($urandom), $urandom, $urandom, 5'($urandom));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);

            if (prev_ready) begin
                check("rnd_throughput", 32'(bus.in_ready), 32'd1);
            end
            check("rnd_out_valid", 32'(bus.out_valid), 32'(q_res.size() != 0));

            if (bus.out_valid && bus.out_ready) begin
                if (q_res.size() != 0) begin
                    check("rnd_result", bus.out_result, q_res.pop_front());
                    check("rnd_tag", 32'(bus.out_tag), 32'(q_tag.pop_front()));
                    check("rnd_err", 32'(bus.out_err), 32'(q_err.pop_front()));
                end
                got++;
            end

            accepted = bus.in_valid && bus.in_ready;
            if (accepted) begin
                m = model(bus.in_funct, bus.in_shamt, bus.in_rs, bus.in_rt);
                q_res.push_back(m[31:0]);
                q_err.push_back(m[32]);
                q_tag.push_back(bus.in_tag);
                sent++;
            end
            prev_ready = bus.out_ready;
            tick();
            cycles++;
            if (accepted) begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check("rnd_timeout", 32'(cycles < 20000), 32'd1);
        check("rnd_delivered", 32'(got), 32'd1000);
        check("rnd_count", 32'(op_count), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
